// File: rtl/peak_report_tx.sv
// Frames each measurement snapshot into an 11-byte packet (header, seq, dc, peak,
// power, XOR checksum) and streams it over a valid/ready byte interface.
module peak_report_tx #(
  parameter logic [7:0] HEADER    = 8'hA5,
  parameter int         DROP_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 snap_strobe,
  input  logic [15:0]          snap_dc,
  input  logic [15:0]          snap_peak,
  input  logic [31:0]          snap_power,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [DROP_BITS-1:0] drops
);

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic [15:0] dc;
    logic [15:0] peak;
    logic [31:0] power;
  } snap_t;

  state_t      state;
  logic [3:0]  idx;
  logic [7:0]  seq;
  logic [7:0]  csum;
  snap_t       act;
  snap_t       pend;
  logic        pend_valid;

  snap_t       in_snap;
  logic [7:0]  next_seq;
  logic        accept;
  logic        last;

  function automatic logic [7:0] calc_csum(input logic [7:0] s, input snap_t d);
    return s ^ d.dc[15:8] ^ d.dc[7:0] ^ d.peak[15:8] ^ d.peak[7:0] ^
           d.power[31:24] ^ d.power[23:16] ^ d.power[15:8] ^ d.power[7:0];
  endfunction

  function automatic logic [7:0] frame_byte(input logic [3:0] i, input logic [7:0] s,
                                            input snap_t d, input logic [7:0] c);
    case (i)
      4'd0:    return HEADER;
      4'd1:    return s;
      4'd2:    return d.dc[15:8];
      4'd3:    return d.dc[7:0];
      4'd4:    return d.peak[15:8];
      4'd5:    return d.peak[7:0];
      4'd6:    return d.power[31:24];
      4'd7:    return d.power[23:16];
      4'd8:    return d.power[15:8];
      4'd9:    return d.power[7:0];
      4'd10:   return c;
      default: return 8'h00;
    endcase
  endfunction

  assign in_snap  = '{dc: snap_dc, peak: snap_peak, power: snap_power};
  assign next_seq = seq + 8'd1;
  assign accept   = out_valid && out_ready;
  assign last     = accept && (idx == 4'd10);
  assign busy     = (state == SEND) || pend_valid;

  // The checksum is latched together with the snapshot it covers, using the seq
  // value that frame will carry, so byte 10 is ready as soon as it is needed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 4'd0;
      seq        <= 8'd0;
      csum       <= 8'd0;
      act        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      out_data   <= 8'd0;
      out_valid  <= 1'b0;
      drops      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (snap_strobe) begin
            act       <= in_snap;
            csum      <= calc_csum(seq, in_snap);
            state     <= SEND;
            idx       <= 4'd0;
            out_valid <= 1'b1;
            out_data  <= HEADER;
          end
        end
        SEND: begin
          if (last) begin
            seq <= next_seq;
            if (pend_valid) begin
              act      <= pend;
              csum     <= calc_csum(next_seq, pend);
              idx      <= 4'd0;
              out_data <= HEADER;
              if (snap_strobe)
                pend <= in_snap;
              else
                pend_valid <= 1'b0;
            end else if (snap_strobe) begin
              act      <= in_snap;
              csum     <= calc_csum(next_seq, in_snap);
              idx      <= 4'd0;
              out_data <= HEADER;
            end else begin
              state     <= IDLE;
              idx       <= 4'd0;
              out_valid <= 1'b0;
              out_data  <= 8'd0;
            end
          end else begin
            if (accept) begin
              idx      <= idx + 4'd1;
              out_data <= frame_byte(idx + 4'd1, seq, act, csum);
            end
            // A strobe mid-frame parks in the single pending slot; an older
            // pending snapshot that never got sent is counted as dropped.
            if (snap_strobe) begin
              if (pend_valid && (drops != '1))
                drops <= drops + 1'b1;
              pend       <= in_snap;
              pend_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
